// File: rtl/ex_md_pkg.sv
// ---------------------------------------------------------------------------
// ex_md_pkg
// Shared types for the EX-stage multiply/divide unit:
//   md_op_e     - 4-bit operation code presented by ID/EX (NONE = 0)
//   md_state_e  - sequencer states of ex_muldiv_unit
//   is_md_start - true for the ops that launch an iterative operation
//   is_md_signed/is_md_div - operation class decoders
// ---------------------------------------------------------------------------
package ex_md_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MFHI  = 4'd7,
        MD_MFLO  = 4'd8
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_FIX  = 2'd2
    } md_state_e;

    function automatic logic is_md_start(input md_op_e op);
        logic res;
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: res = 1'b1;
            default:                            res = 1'b0;
        endcase
        return res;
    endfunction

    function automatic logic is_md_signed(input md_op_e op);
        logic res;
        case (op)
            MD_MULT, MD_DIV: res = 1'b1;
            default:         res = 1'b0;
        endcase
        return res;
    endfunction

    function automatic logic is_md_div(input md_op_e op);
        logic res;
        case (op)
            MD_DIV, MD_DIVU: res = 1'b1;
            default:         res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/md_iter_core.sv
// ---------------------------------------------------------------------------
// md_iter_core
// Per-iteration datapath of the multi-cycle multiply/divide unit. Works on
// unsigned magnitudes only; sign handling lives in the parent.
//   clk, rst_n  - clock, synchronous active-low reset
//   load        - capture op_a into the shift register, op_b as the
//                 multiplicand/divisor, clear the accumulator
//   step        - perform one iteration (is_div selects the algorithm)
//   is_div      - 1: restoring divide, 0: shift-add multiply
//   op_a, op_b  - operand magnitudes
//   acc_q       - accumulator: product high half / remainder
//   mq_q        - shift register: product low half / quotient
// ---------------------------------------------------------------------------
module md_iter_core #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            step,
    input  logic            is_div,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [XLEN-1:0] acc_q,
    output logic [XLEN-1:0] mq_q
);

    logic [XLEN-1:0] acc_r;
    logic [XLEN-1:0] mq_r;
    logic [XLEN-1:0] opb_r;

    logic [XLEN:0]   mul_sum_s;
    logic [XLEN:0]   div_shift_s;
    logic [XLEN-1:0] div_diff_s;
    logic            div_ge_s;

    // Iteration arithmetic: conditional add for multiply, trial subtract for divide
    always_comb begin
        mul_sum_s   = {1'b0, acc_r} + (mq_r[0] ? {1'b0, opb_r} : {(XLEN+1){1'b0}});
        div_shift_s = {acc_r, mq_r[XLEN-1]};
        div_ge_s    = (div_shift_s >= {1'b0, opb_r});
        // When the trial succeeds the true difference is below opb_r, so the
        // low XLEN bits of the subtraction are exact.
        div_diff_s  = div_shift_s[XLEN-1:0] - opb_r;
    end

    // Accumulator / shift register / operand update
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_r <= {XLEN{1'b0}};
            mq_r  <= {XLEN{1'b0}};
            opb_r <= {XLEN{1'b0}};
        end else if (load) begin
            acc_r <= {XLEN{1'b0}};
            mq_r  <= op_a;
            opb_r <= op_b;
        end else if (step) begin
            if (is_div) begin
                if (div_ge_s) begin
                    acc_r <= div_diff_s;
                    mq_r  <= {mq_r[XLEN-2:0], 1'b1};
                end else begin
                    acc_r <= div_shift_s[XLEN-1:0];
                    mq_r  <= {mq_r[XLEN-2:0], 1'b0};
                end
            end else begin
                // {acc, mq} shifts right one place per step; the carry of the
                // add lands in the accumulator MSB.
                acc_r <= mul_sum_s[XLEN:1];
                mq_r  <= {mul_sum_s[0], mq_r[XLEN-1:1]};
            end
        end
    end

    assign acc_q = acc_r;
    assign mq_q  = mq_r;

endmodule

// File: rtl/ex_muldiv_unit.sv
// ---------------------------------------------------------------------------
// ex_muldiv_unit
// Multi-cycle multiply/divide unit for the EX stage with architectural HI/LO.
// Handles MULT/MULTU/DIV/DIVU (iterative, stalls the front end), MTHI/MTLO
// and MFHI/MFLO (single cycle), and a kill from later pipeline stages.
//   clk, rst_n      - clock, synchronous active-low reset
//   in_valid        - an instruction is present in EX
//   md_op           - operation (md_op_e)
//   src_a, src_b    - rs / rt values
//   kill            - abort the in-flight operation
//   md_stall        - hold IF, IF/ID and ID/EX this cycle
//   md_result       - HI for MFHI, LO for MFLO, otherwise 0 (combinational)
//   md_result_valid - MFHI/MFLO accepted this cycle
//   hi_q, lo_q      - current HI/LO
// Build option: define EX_FAST_MUL_EN to finish MULT/MULTU in the issue cycle
// with a combinational multiplier; divides remain iterative.
// ---------------------------------------------------------------------------
module ex_muldiv_unit
    import ex_md_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  md_op_e          md_op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            kill,
    output logic            md_stall,
    output logic [XLEN-1:0] md_result,
    output logic            md_result_valid,
    output logic [XLEN-1:0] hi_q,
    output logic [XLEN-1:0] lo_q
);

    localparam int             CNT_W    = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    md_state_e         state_r;
    md_state_e         state_n_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_n_s;

    logic [XLEN-1:0]   hi_r;
    logic [XLEN-1:0]   lo_r;
    logic              sa_r;
    logic              sb_r;
    logic              div0_r;
    logic              is_div_r;

    logic              idle_s;
    logic              start_s;
    logic              iter_start_s;
    logic              fast_mul_s;
    logic              op_signed_s;
    logic              op_div_s;
    logic              a_neg_s;
    logic              b_neg_s;
    logic [XLEN-1:0]   abs_a_s;
    logic [XLEN-1:0]   abs_b_s;
    logic              mt_hi_s;
    logic              mt_lo_s;
    logic              step_s;

    logic [XLEN-1:0]   core_acc_s;
    logic [XLEN-1:0]   core_mq_s;
    logic [2*XLEN-1:0] prod_s;
    logic [2*XLEN-1:0] prod_fix_s;
    logic [XLEN-1:0]   quo_fix_s;
    logic [XLEN-1:0]   rem_fix_s;
    logic [2*XLEN-1:0] fast_prod_s;

    // Issue decode and operand magnitude preparation
    always_comb begin
        idle_s      = (state_r == ST_IDLE);
        start_s     = in_valid && idle_s && !kill && is_md_start(md_op);
        op_signed_s = is_md_signed(md_op);
        op_div_s    = is_md_div(md_op);
        a_neg_s     = op_signed_s && src_a[XLEN-1];
        b_neg_s     = op_signed_s && src_b[XLEN-1];
        abs_a_s     = a_neg_s ? -src_a : src_a;
        abs_b_s     = b_neg_s ? -src_b : src_b;
        mt_hi_s     = in_valid && idle_s && !kill && (md_op == MD_MTHI);
        mt_lo_s     = in_valid && idle_s && !kill && (md_op == MD_MTLO);
        step_s      = (state_r == ST_BUSY) && !kill;
    end

`ifdef EX_FAST_MUL_EN
    // Multiplies bypass the sequencer; sign-extending to 2*XLEN gives the
    // signed product for MULT and the unsigned one for MULTU.
    assign iter_start_s = start_s && op_div_s;
    assign fast_mul_s   = start_s && !op_div_s;
    assign fast_prod_s  = {{XLEN{a_neg_s}}, src_a} * {{XLEN{b_neg_s}}, src_b};
`else
    assign iter_start_s = start_s;
    assign fast_mul_s   = 1'b0;
    assign fast_prod_s  = {(2*XLEN){1'b0}};
`endif

    md_iter_core #(
        .XLEN (XLEN)
    ) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (iter_start_s),
        .step   (step_s),
        .is_div (is_div_r),
        .op_a   (abs_a_s),
        .op_b   (abs_b_s),
        .acc_q  (core_acc_s),
        .mq_q   (core_mq_s)
    );

    // Sign correction of the magnitude results, consumed in FIX
    always_comb begin
        prod_s     = {core_acc_s, core_mq_s};
        prod_fix_s = (sa_r ^ sb_r) ? -prod_s : prod_s;
        // A zero divisor yields an all-ones quotient regardless of signs;
        // the remainder is then |dividend| re-signed, i.e. the dividend.
        quo_fix_s  = div0_r ? {XLEN{1'b1}} : ((sa_r ^ sb_r) ? -core_mq_s : core_mq_s);
        rem_fix_s  = sa_r ? -core_acc_s : core_acc_s;
    end

    // Sequencer next state
    always_comb begin
        state_n_s = state_r;
        cnt_n_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (iter_start_s) begin
                    state_n_s = ST_BUSY;
                    cnt_n_s   = CNT_LAST;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (kill) begin
                    state_n_s = ST_IDLE;
                end else if (cnt_r == CNT_ZERO) begin
                    state_n_s = ST_FIX;
                end else begin
                    cnt_n_s = cnt_r - CNT_ONE;
                end
            end
            ST_FIX: begin
                state_n_s = ST_IDLE;
            end
            default: begin
                state_n_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and iteration counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_n_s;
            cnt_r   <= cnt_n_s;
        end
    end

    // Sign flags and operation class captured at issue
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sa_r     <= 1'b0;
            sb_r     <= 1'b0;
            div0_r   <= 1'b0;
            is_div_r <= 1'b0;
        end else if (iter_start_s) begin
            sa_r     <= a_neg_s;
            sb_r     <= b_neg_s;
            div0_r   <= (src_b == {XLEN{1'b0}});
            is_div_r <= op_div_s;
        end
    end

    // Architectural HI/LO; kill blocks every write, including the FIX write
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_r <= {XLEN{1'b0}};
            lo_r <= {XLEN{1'b0}};
        end else if (!kill) begin
            if (state_r == ST_FIX) begin
                if (is_div_r) begin
                    hi_r <= rem_fix_s;
                    lo_r <= quo_fix_s;
                end else begin
                    {hi_r, lo_r} <= prod_fix_s;
                end
            end else if (fast_mul_s) begin
                {hi_r, lo_r} <= fast_prod_s;
            end else if (mt_hi_s) begin
                hi_r <= src_a;
            end else if (mt_lo_s) begin
                lo_r <= src_a;
            end
        end
    end

    // MFxx read path and stall
    always_comb begin
        case (md_op)
            MD_MFHI: md_result = hi_r;
            MD_MFLO: md_result = lo_r;
            default: md_result = {XLEN{1'b0}};
        endcase
        md_result_valid = in_valid && idle_s && ((md_op == MD_MFHI) || (md_op == MD_MFLO));
        md_stall        = in_valid && (iter_start_s || (state_r == ST_BUSY));
    end

    assign hi_q = hi_r;
    assign lo_q = lo_r;

endmodule
